sensor_reader: RTL and testbench
================================

SENSOR_READER -- requirements
Module: sensor_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 3: sensor address bits on GPIO_1, legal range 1..4.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required before acceptance, minimum 1.
REQ-003 SHALL have parameter DEPTH, default 4: hit-event FIFO entries, power of two, minimum 2.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-006 Port reset  input  1  synchronous active-high reset.
REQ-007 Port GPIO_1  input  WIDTH  raw asynchronous sensor address; 0 means no box hit.
REQ-008 Port hit_ready  input  1  consumer accepts head event this cycle.
REQ-009 Port box_address  output  WIDTH  debounced stable address.
REQ-010 Port hit_valid  output  1  FIFO non-empty; head event offered.
REQ-011 Port hit_address  output  WIDTH  FIFO head address; 0 when empty.
REQ-012 Port overflow  output  1  sticky flag: an event was dropped.
REQ-013 Port hit_count  output  8  accepted-event counter.
REQ-014 Port LEDR  output  10  status LEDs.
REQ-015 Port HEX0  output  7  active-low 7-seg: box_address.
REQ-016 Port HEX1  output  7  active-low 7-seg: FIFO occupancy.

Function
REQ-017 GPIO_1 SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-018 Debounce SHALL hold a candidate register cand and a counter cnt sized for DEBOUNCE_CYCLES-1.
- If s2 != cand: cand<=s2, cnt<=0.
- Else if cnt == DEBOUNCE_CYCLES-1 and cand != box_address: box_address<=cand.
- Else if cnt < DEBOUNCE_CYCLES-1: cnt<=cnt+1.
REQ-019 A GPIO_1 change held constant SHALL reach box_address on exactly the (3+DEBOUNCE_CYCLES)th rising edge after the change; any glitch shorter than that SHALL restart the count and never reach box_address.
REQ-020 An event SHALL be generated on the edge box_address updates to a nonzero value; updates to 0 generate no event.
REQ-021 Events SHALL be pushed into a DEPTH-entry FIFO on the same edge; hit_valid SHALL assert in the following cycle.
REQ-022 Pop SHALL occur when hit_valid && hit_ready; hit_ready while empty SHALL have no effect.
REQ-023 When full, a push with a simultaneous pop SHALL succeed with no loss; a push without a pop SHALL be dropped and overflow set.
REQ-024 overflow SHALL stay set until reset.
REQ-025 hit_count SHALL increment on every successful push, wrapping 255->0; a dropped event SHALL not count.
REQ-026 Occupancy SHALL range 0..DEPTH; a simultaneous push and pop when non-empty and non-full SHALL leave occupancy unchanged.
REQ-027 LEDR outputs:
- LEDR[WIDTH-1:0]=box_address
- LEDR[8]=hit_valid
- LEDR[9]=overflow
- all other bits 0
REQ-028 HEX0 SHALL display box_address zero-extended to 4 bits, and HEX1 occupancy (saturated at F), both as standard active-low hex glyphs 0-F (segment 0 = lit).

Reset
REQ-029 On reset, s1, s2, cand, cnt, box_address, overflow and hit_count SHALL be 0 and the FIFO empty (hit_valid=0, hit_address=0).
REQ-030 On reset, LEDR SHALL be 0, HEX0 SHALL show "0" (7'b1000000) and HEX1 SHALL show "0".
REQ-031 Reset asserted mid-debounce or with a non-empty FIFO SHALL discard all pending state on that edge; a GPIO_1 value held through reset SHALL be re-debounced from zero after release.

Verification
REQ-032 DEBOUNCE_CYCLES=4: GPIO_1 0->5 held -> box_address=5 and FIFO push at edge 7; hit_valid=1, hit_address=5, HEX0=7'b0010010 from the next cycle.
REQ-033 DEBOUNCE_CYCLES=4: GPIO_1=3 pulsed for 3 cycles, then 0 -> box_address stays 0, no event, hit_count=0.
REQ-034 DEPTH=4, hit_ready=0, addresses 1,2,3,4,5 each held and debounced -> occupancy 4, overflow=1, hit_count=4; draining then yields 1,2,3,4 in order.
REQ-035 FIFO full, hit_ready=1 on the cycle of a fifth push -> no drop, overflow=0, occupancy stays 4.
REQ-036 Sequence 6 -> 0 -> 6 -> two events of address 6; repeat of the same nonzero value without an intervening 0 -> no second event.
REQ-037 Reset asserted with 2 queued events and cnt mid-count -> next cycle hit_valid=0, hit_count=0, box_address=0.

Source files
------------

// File: rtl/sensor_reader.sv
// sensor_reader: synchronizes and debounces a raw sensor address, turns every
// settle onto a nonzero address into a hit event, queues those events in a
// small FIFO for a consumer, and drives status LEDs and two hex digits.
module sensor_reader #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEPTH           = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] GPIO_1,
    input  logic             hit_ready,
    output logic [WIDTH-1:0] box_address,
    output logic             hit_valid,
    output logic [WIDTH-1:0] hit_address,
    output logic             overflow,
    output logic [7:0]       hit_count,
    output logic [9:0]       LEDR,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] s1, s2, cand;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] occ;

    logic accept, push_req, push_ok, pop, full, empty;
    logic [3:0] box_nib, occ_nib;

    // Debounce decision: the candidate has been stable long enough and differs
    // from what is currently published. Only nonzero settles become events.
    assign accept   = (s2 == cand) && (cnt == CNT_MAX) && (cand != box_address);
    assign push_req = accept && (cand != '0);

    // Handshake: hit_valid/hit_address present the FIFO head; an event is
    // consumed on any rising edge where hit_valid && hit_ready. hit_ready while
    // hit_valid is low is ignored. The head is held stable until consumed.
    assign full      = (occ == OCC_W'(DEPTH));
    assign empty     = (occ == '0);
    assign hit_valid = !empty;
    assign pop       = hit_valid && hit_ready;
    // A full FIFO still takes a new event when the head leaves on the same edge.
    assign push_ok   = push_req && (!full || pop);
    assign hit_address = empty ? '0 : mem[rd_ptr];

    // Two-flop synchronizer followed by the candidate/stability-counter debounce.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1          <= '0;
            s2          <= '0;
            cand        <= '0;
            cnt         <= '0;
            box_address <= '0;
        end else begin
            s1 <= GPIO_1;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CNT_MAX) begin
                if (cand != box_address) begin
                    box_address <= cand;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because empty masks the head.
    always_ff @(posedge CLOCK_50) begin
        if (push_ok) begin
            mem[wr_ptr] <= cand;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and accepted-event counter.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            overflow  <= 1'b0;
            hit_count <= 8'd0;
        end else begin
            if (push_ok) begin
                wr_ptr    <= wr_ptr + PTR_W'(1);
                hit_count <= hit_count + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (pop && !push_ok) begin
                occ <= occ - OCC_W'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Status LEDs and hex digits; occupancy saturates at F on the display.
    always_comb begin
        LEDR               = '0;
        LEDR[WIDTH-1:0]    = box_address;
        LEDR[8]            = hit_valid;
        LEDR[9]            = overflow;
        box_nib            = 4'(box_address);
        if (int'(occ) > 15) begin
            occ_nib = 4'hF;
        end else begin
            occ_nib = 4'(occ);
        end
        HEX0 = hex_glyph(box_nib);
        HEX1 = hex_glyph(occ_nib);
    end

endmodule

// File: tb/tb_sensor_reader.sv
// tb_sensor_reader: directed scenarios plus randomized address/ready traffic,
// checked every cycle against a behavioural model of the sensor reader.
module tb_sensor_reader;

    localparam int W  = 3;
    localparam int DB = 4;
    localparam int DP = 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [W-1:0] gpio;
    logic         hit_ready;
    logic [W-1:0] box_address;
    logic         hit_valid;
    logic [W-1:0] hit_address;
    logic         overflow;
    logic [7:0]   hit_count;
    logic [9:0]   LEDR;
    logic [6:0]   HEX0;
    logic [6:0]   HEX1;

    sensor_reader #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .DEPTH(DP)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .GPIO_1      (gpio),
        .hit_ready   (hit_ready),
        .box_address (box_address),
        .hit_valid   (hit_valid),
        .hit_address (hit_address),
        .overflow    (overflow),
        .hit_count   (hit_count),
        .LEDR        (LEDR),
        .HEX0        (HEX0),
        .HEX1        (HEX1)
    );

    int checks = 0;
    int errors = 0;
    string phase = "init";

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model. A raw value is accepted once it has been seen at D+1
    // consecutive edges; synchronizer plus candidate capture make that visible
    // two edges after the last of those samples. hist holds the last DB+3 raw
    // samples, oldest first, so the window is hist[0..DB].
    int exp_q[$];
    int hist[$];
    int box_m   = 0;
    bit ovf_m   = 0;
    int cnt_m   = 0;
    int v_m;
    bit stable_m, ev_m, pop_m;

    always @(posedge clk) begin
        if (reset) begin
            hist.delete();
            for (int i = 0; i < DB + 3; i++) hist.push_back(0);
            box_m = 0;
            exp_q.delete();
            ovf_m = 0;
            cnt_m = 0;
        end else begin
            pop_m = (exp_q.size() > 0) && hit_ready;
            hist.push_back(int'(gpio));
            void'(hist.pop_front());
            v_m = hist[0];
            stable_m = 1'b1;
            for (int i = 1; i <= DB; i++) if (hist[i] != v_m) stable_m = 1'b0;
            ev_m = 1'b0;
            if (stable_m && v_m != box_m) begin
                box_m = v_m;
                ev_m  = (v_m != 0);
            end
            if (pop_m) void'(exp_q.pop_front());
            if (ev_m) begin
                if (exp_q.size() < DP) begin
                    exp_q.push_back(v_m);
                    cnt_m = (cnt_m + 1) % 256;
                end else begin
                    ovf_m = 1'b1;
                end
            end
        end
    end

    // scoreboard
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int occ;
        logic [31:0] e_ledr;
        occ = exp_q.size();
        e_ledr = 32'(box_m) | ((occ > 0) ? 32'h100 : 32'h0) | (ovf_m ? 32'h200 : 32'h0);
        chk("box",   32'(box_address), 32'(box_m));
        chk("valid", 32'(hit_valid), (occ > 0) ? 32'd1 : 32'd0);
        chk("addr",  32'(hit_address), (occ > 0) ? 32'(exp_q[0]) : 32'd0);
        chk("ovf",   32'(overflow), 32'(ovf_m));
        chk("count", 32'(hit_count), 32'(cnt_m));
        chk("ledr",  32'(LEDR), e_ledr);
        chk("hex0",  32'(HEX0), 32'(glyph[box_m]));
        chk("hex1",  32'(HEX1), 32'(glyph[(occ > 15) ? 15 : occ]));
    endtask

    // driver: apply inputs for one edge, then check at the following negedge
    task automatic cycle(input int g, input bit r, input bit rst);
        gpio      = W'(g);
        hit_ready = r;
        reset     = rst;
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input int g, input bit r, input int n);
        for (int i = 0; i < n; i++) cycle(g, r, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        gpio      = '0;
        hit_ready = 1'b0;

        phase = "reset";
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        chk("ledr0", 32'(LEDR), 32'd0);
        chk("hex0_0", 32'(HEX0), 32'h40);
        chk("hex1_0", 32'(HEX1), 32'h40);
        chk("valid0", 32'(hit_valid), 32'd0);

        phase = "debounce5";
        for (int i = 1; i <= 7; i++) begin
            cycle(5, 0, 0);
            if (i == 6) chk("box_e6", 32'(box_address), 32'd0);
            if (i == 7) begin
                chk("box_e7", 32'(box_address), 32'd5);
                chk("valid_e7", 32'(hit_valid), 32'd1);
                chk("addr_e7", 32'(hit_address), 32'd5);
                chk("hex0_e7", 32'(HEX0), 32'b0010010);
            end
        end
        hold(0, 1, 10);

        phase = "glitch";
        cycle(0, 0, 1);
        hold(3, 0, 3);
        hold(0, 0, 10);
        chk("glitch_box", 32'(box_address), 32'd0);
        chk("glitch_cnt", 32'(hit_count), 32'd0);
        chk("glitch_valid", 32'(hit_valid), 32'd0);

        phase = "overflow";
        cycle(0, 0, 1);
        for (int a = 1; a <= 5; a++) hold(a, 0, 8);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(hit_count), 32'd4);
        chk("ovf_occ", 32'(HEX1), 32'b0011001);
        for (int k = 1; k <= 4; k++) begin
            chk("drain", 32'(hit_address), 32'(k));
            cycle(5, 1, 0);
        end
        chk("drained", 32'(hit_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        phase = "full_pop";
        cycle(0, 0, 1);
        for (int a = 1; a <= 4; a++) hold(a, 0, 8);
        hold(5, 0, 6);
        cycle(5, 1, 0);
        hold(5, 0, 3);
        chk("fp_ovf", 32'(overflow), 32'd0);
        chk("fp_occ", 32'(HEX1), 32'b0011001);
        chk("fp_cnt", 32'(hit_count), 32'd5);
        chk("fp_head", 32'(hit_address), 32'd2);

        phase = "repeat6";
        cycle(0, 0, 1);
        hold(6, 0, 8);
        hold(0, 0, 8);
        hold(6, 0, 8);
        chk("r6_cnt", 32'(hit_count), 32'd2);
        hold(5, 0, 2);
        hold(6, 0, 10);
        chk("r6_norepeat", 32'(hit_count), 32'd2);
        chk("r6_box", 32'(box_address), 32'd6);

        phase = "midreset";
        cycle(0, 0, 1);
        hold(1, 0, 8);
        hold(2, 0, 8);
        hold(3, 0, 4);
        cycle(3, 0, 1);
        chk("mr_valid", 32'(hit_valid), 32'd0);
        chk("mr_cnt", 32'(hit_count), 32'd0);
        chk("mr_box", 32'(box_address), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            cycle(3, 0, 0);
            if (i == 6) chk("mr_e6", 32'(box_address), 32'd0);
            if (i == 7) chk("mr_e7", 32'(box_address), 32'd3);
        end

        phase = "random";
        for (int n = 0; n < 150; n++) begin
            int g, len;
            g   = int'($urandom_range(0, 7));
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) begin
                cycle(g, ($urandom_range(0, 2) == 0), ($urandom_range(0, 199) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
